// File: rtl/bus_pkg.sv
// Shared definitions for the native valid/ready memory bus: arbiter state
// encoding, master indices and the default error read data.
package bus_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2,
        ERR  = 2'd3
    } arb_state_e;

    localparam logic M_CPU = 1'b0;
    localparam logic M_DMA = 1'b1;

    localparam logic [31:0] ERR_RDATA_DEFAULT = 32'hFFFF_FFFF;

    // One-hot bus owner implied by an arbiter state; nobody owns the bus in IDLE/ERR.
    function automatic logic [1:0] state_grant(input arb_state_e st);
        case (st)
            GNT0:    return 2'b01;
            GNT1:    return 2'b10;
            default: return 2'b00;
        endcase
    endfunction

endpackage

// File: rtl/bus_timeout.sv
// Response timeout counter: cleared while no access is pending, counts stalled
// cycles, and flags expiry on the last allowed cycle. LIMIT of 0 never expires.
module bus_timeout #(
    parameter int LIMIT = 64,
    parameter int CNT_W = 8
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clear_i,
    input  logic enable_i,
    output logic expire_o
);

    localparam logic [CNT_W-1:0] LAST = CNT_W'(LIMIT - 1);

    logic [CNT_W-1:0] cnt_q;
    logic [CNT_W-1:0] cnt_d;

    // Next count: clear dominates, otherwise advance on each stalled cycle.
    always_comb begin
        cnt_d = cnt_q;
        if (clear_i) begin
            cnt_d = '0;
        end else if (enable_i) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expire_o = (LIMIT != 0) && (cnt_q == LAST);

endmodule

// File: rtl/mem_bus_arbiter.sv
// Two-master (CPU, DMA) to one-slave arbiter for the valid/ready memory bus,
// with a response timeout that completes unmapped accesses with an error.
module mem_bus_arbiter
    import bus_pkg::*;
#(
    parameter int          ARB_MODE       = 0,
    parameter int          TIMEOUT_CYCLES = 64,
    parameter logic [31:0] ERR_RDATA      = ERR_RDATA_DEFAULT,
    parameter int          CNT_W          = 8
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        m0_valid,
    input  logic        m0_instr,
    input  logic [31:0] m0_addr,
    input  logic [31:0] m0_wdata,
    input  logic [3:0]  m0_wstrb,
    output logic        m0_ready,
    output logic [31:0] m0_rdata,
    input  logic        m1_valid,
    input  logic [31:0] m1_addr,
    input  logic [31:0] m1_wdata,
    input  logic [3:0]  m1_wstrb,
    output logic        m1_ready,
    output logic [31:0] m1_rdata,
    output logic        s_valid,
    output logic        s_instr,
    output logic [31:0] s_addr,
    output logic [31:0] s_wdata,
    output logic [3:0]  s_wstrb,
    input  logic        s_ready,
    input  logic [31:0] s_rdata,
    output logic [1:0]  grant,
    output logic        bus_error,
    output logic        err_flag,
    output logic        err_master,
    output logic [31:0] err_addr,
    input  logic        err_clr
);

    arb_state_e  state_q, state_d;
    logic        last_grant_q, last_grant_d;
    logic [1:0]  grant_q;
    logic        bus_error_q;
    logic        err_flag_q, err_flag_d;
    logic        err_master_q, err_master_d;
    logic [31:0] err_addr_q, err_addr_d;
    logic        cnt_clr_s, cnt_en_s, expire_s;
    logic        s_valid_s;
    logic [31:0] s_addr_s;

    bus_timeout #(
        .LIMIT (TIMEOUT_CYCLES),
        .CNT_W (CNT_W)
    ) u_timeout (
        .clk      (clk),
        .rst_n    (reset_n),
        .clear_i  (cnt_clr_s),
        .enable_i (cnt_en_s),
        .expire_o (expire_s)
    );

    // Bus mux toward the slave and response demux toward the masters.
    always_comb begin
        s_valid_s = 1'b0;
        s_instr   = 1'b0;
        s_addr_s  = 32'h0000_0000;
        s_wdata   = 32'h0000_0000;
        s_wstrb   = 4'b0000;
        m0_ready  = 1'b0;
        m0_rdata  = 32'h0000_0000;
        m1_ready  = 1'b0;
        m1_rdata  = 32'h0000_0000;
        case (state_q)
            GNT0: begin
                s_valid_s = m0_valid;
                s_instr   = m0_instr;
                s_addr_s  = m0_addr;
                s_wdata   = m0_wdata;
                s_wstrb   = m0_wstrb;
                m0_ready  = s_ready;
                m0_rdata  = s_rdata;
            end
            GNT1: begin
                s_valid_s = m1_valid;
                s_addr_s  = m1_addr;
                s_wdata   = m1_wdata;
                s_wstrb   = m1_wstrb;
                m1_ready  = s_ready;
                m1_rdata  = s_rdata;
            end
            ERR: begin
                // The slave is never driven here, so a timed-out write is dropped.
                if (err_master_q == M_DMA) begin
                    m1_ready = 1'b1;
                    m1_rdata = ERR_RDATA;
                end else begin
                    m0_ready = 1'b1;
                    m0_rdata = ERR_RDATA;
                end
            end
            default: begin
                s_valid_s = 1'b0;
            end
        endcase
    end

    // Arbitration and access sequencing; completion takes priority over expiry.
    always_comb begin
        state_d      = state_q;
        last_grant_d = last_grant_q;
        cnt_clr_s    = 1'b0;
        cnt_en_s     = 1'b0;
        case (state_q)
            IDLE: begin
                cnt_clr_s = 1'b1;
                if (m0_valid && m1_valid) begin
                    if ((ARB_MODE == 1) || (last_grant_q == M_DMA)) begin
                        state_d      = GNT0;
                        last_grant_d = M_CPU;
                    end else begin
                        state_d      = GNT1;
                        last_grant_d = M_DMA;
                    end
                end else if (m0_valid) begin
                    state_d      = GNT0;
                    last_grant_d = M_CPU;
                end else if (m1_valid) begin
                    state_d      = GNT1;
                    last_grant_d = M_DMA;
                end else begin
                    state_d = IDLE;
                end
            end
            GNT0, GNT1: begin
                if (!s_valid_s) begin
                    state_d = IDLE;
                end else if (s_ready) begin
                    state_d = IDLE;
                end else if (expire_s) begin
                    state_d = ERR;
                end else begin
                    state_d  = state_q;
                    cnt_en_s = 1'b1;
                end
            end
            ERR: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Error capture on the timeout edge; a coinciding err_clr loses to the set.
    always_comb begin
        err_flag_d   = err_flag_q;
        err_master_d = err_master_q;
        err_addr_d   = err_addr_q;
        if ((state_d == ERR) && (state_q != ERR)) begin
            err_flag_d   = 1'b1;
            err_master_d = (state_q == GNT1) ? M_DMA : M_CPU;
            err_addr_d   = s_addr_s;
        end else if (err_clr) begin
            err_flag_d = 1'b0;
        end else begin
            err_flag_d = err_flag_q;
        end
    end

    // State, grant and error registers.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= IDLE;
            last_grant_q <= M_DMA;
            grant_q      <= 2'b00;
            bus_error_q  <= 1'b0;
            err_flag_q   <= 1'b0;
            err_master_q <= 1'b0;
            err_addr_q   <= 32'h0000_0000;
        end else begin
            state_q      <= state_d;
            last_grant_q <= last_grant_d;
            grant_q      <= state_grant(state_d);
            bus_error_q  <= (state_d == ERR);
            err_flag_q   <= err_flag_d;
            err_master_q <= err_master_d;
            err_addr_q   <= err_addr_d;
        end
    end

    assign s_valid    = s_valid_s;
    assign s_addr     = s_addr_s;
    assign grant      = grant_q;
    assign bus_error  = bus_error_q;
    assign err_flag   = err_flag_q;
    assign err_master = err_master_q;
    assign err_addr   = err_addr_q;

endmodule

// File: doc/mem_bus_arbiter.md
Name: mem_bus_arbiter

Overview:
Two-master to one-slave arbiter for the native valid/ready memory bus. Master 0 is the picorv32 CPU and master 1 is a bus master such as a DMA engine. It sits between the masters and the existing address decoder, which still sees a single mem_valid/mem_ready bus. It also adds a response timeout, so that an access to an unmapped address completes with an error instead of hanging the CPU.

Parameters:
ARB_MODE, 0, arbitration policy: 0 = round-robin, 1 = fixed priority with m0 highest
TIMEOUT_CYCLES, 64, maximum cycles a granted access waits for s_ready; 0 disables the timeout
ERR_RDATA, 32'hFFFF_FFFF, read data returned on a timed-out access
CNT_W, 8, width of the timeout counter; must hold TIMEOUT_CYCLES-1

Ports:
clk  input  1  system clock
reset_n  input  1  asynchronous active-low reset
m0_valid  input  1  CPU request; held until m0_ready
m0_instr  input  1  CPU instruction-fetch qualifier
m0_addr  input  32  CPU byte address
m0_wdata  input  32  CPU write data
m0_wstrb  input  4  CPU byte strobes; 0 means read
m0_ready  output  1  CPU access complete
m0_rdata  output  32  CPU read data
m1_valid  input  1  DMA request; held until m1_ready
m1_addr  input  32  DMA byte address
m1_wdata  input  32  DMA write data
m1_wstrb  input  4  DMA byte strobes
m1_ready  output  1  DMA access complete
m1_rdata  output  32  DMA read data
s_valid  output  1  request to the decoder/slaves
s_instr  output  1  m0_instr when m0 is granted, else 0
s_addr  output  32  muxed address
s_wdata  output  32  muxed write data
s_wstrb  output  4  muxed strobes
s_ready  input  1  slave completion
s_rdata  input  32  slave read data
grant  output  2  one-hot owner: bit0 = m0, bit1 = m1
bus_error  output  1  one-cycle pulse on timeout
err_flag  output  1  sticky timeout flag
err_master  output  1  master that last timed out
err_addr  output  32  address of the last timed-out access
err_clr  input  1  clears err_flag

Behaviour:
- Reset: one clock domain, clk; reset_n is asynchronous and active-low.
  - State goes to IDLE; last_grant = 1, so m0 wins the first tie.
  - All outputs are 0: m*_ready, s_valid, grant, bus_error, err_flag, err_master, err_addr, and all data/address outputs.
- States: IDLE, GNT0, GNT1, ERR.
- IDLE:
  - No request: stay in IDLE.
  - Only mX_valid: go to GNTX at the next edge.
  - Both valid, ARB_MODE=0: grant the master that is not last_grant.
  - Both valid, ARB_MODE=1: grant m0.
  - last_grant updates on every grant.
  - Timeout counter clears on entry to GNTx.
- Latency: a request seen in IDLE in cycle N gives grant and s_valid in cycle N+1. Minimum access is 2 cycles including the IDLE arbitration cycle.
- GNTx outputs:
  - s_valid = mX_valid (combinational); s_addr/s_wdata/s_wstrb are muxed from mX.
  - mX_ready = s_ready and mX_rdata = s_rdata (combinational).
  - The non-granted master sees ready = 0 and rdata = 0.
  - In IDLE and ERR, s_addr, s_wdata and s_wstrb are 0.
- GNTx transitions:
  - s_ready=1 returns to IDLE at the next edge. There is always one IDLE cycle between accesses, which guarantees fairness.
  - s_ready=0 increments the counter.
  - Counter == TIMEOUT_CYCLES-1 with s_ready=0 (and TIMEOUT_CYCLES≠0) goes to ERR.
  - If s_ready and timeout expiry occur in the same cycle, normal completion wins.
- ERR (one cycle):
  - s_valid = 0; mX_ready = 1; mX_rdata = ERR_RDATA; writes are dropped.
  - bus_error = 1; err_flag is set; err_master and err_addr are captured.
  - Next state is IDLE.
- Master drops valid while granted (protocol violation, tolerated): s_valid follows it low, and the arbiter returns to IDLE at the next edge with no ready.
- err_clr: clears err_flag at the next edge. If it coincides with a new timeout, the set wins.
- grant is registered, one-hot, and 0 in IDLE and ERR.
- Reset during an access: returns to IDLE immediately with all outputs 0. The master must reissue.

Decomposition:
- Shared package bus_pkg holds:
  - state encoding (IDLE/GNT0/GNT1/ERR)
  - master index constants M_CPU=0, M_DMA=1
  - ERR_RDATA default
- The timeout counter is a natural sub-module: bus_timeout (clear, enable, expire), reusable by the planned bus bridge.

Test Plan:
- m0 reads 0x0002_0000 alone, slave ready in the 3rd granted cycle with rdata 0x1234_5678 -> grant=01 from cycle 1, m0_ready in cycle 3 with m0_rdata 0x1234_5678; IDLE in cycle 4.
- m0 and m1 request together continuously with ARB_MODE=0 and single-cycle slave -> grants alternate 01,10,01,10 starting with m0; with ARB_MODE=1 -> always 01.
- m1 writes 0xA5 to 0x8000_0000 with wstrb=0001 while m0 is idle -> s_addr=0x8000_0000, s_wdata=0xA5, s_wstrb=0001, s_instr=0; m0_ready stays 0.
- m0 reads unmapped 0x4000_0000 with no s_ready and TIMEOUT_CYCLES=8 -> after 8 granted cycles, one ERR cycle with m0_ready=1, rdata=0xFFFF_FFFF, bus_error pulse; err_flag=1, err_addr=0x4000_0000, err_master=0; err_clr clears err_flag.
- s_ready arrives exactly on the final timeout cycle -> normal completion with slave rdata; bus_error stays 0.
- reset_n asserted mid-GNT1 -> all outputs 0 asynchronously; after release, a pending m0 request is granted first (last_grant=1).
